// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM bus: the opcodes the controller issues,
// the address length, and the responder FSM encoding shown on the debug display.
package psram_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h0B;
  localparam int         ADDR_BYTES = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_WDATA  = 3'd4,
    ST_RDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

endpackage

// File: rtl/psram_responder_if.sv
// Byte-wide SDR PSRAM bus as seen from the initiator (master) and the
// device end (slave).
interface psram_responder_if;

  logic       i_csn;
  logic       i_sclk;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       o_data_oe;

  modport master (output i_csn, output i_sclk, output i_data,
                  input  o_data, input o_data_oe);
  modport slave  (input  i_csn, input  i_sclk, input  i_data,
                  output o_data, output o_data_oe);

endinterface

// File: rtl/psram_resp_mem.sv
// Single-port byte RAM backing the responder; read data is registered so it
// maps onto block RAM.
module psram_resp_mem #(
  parameter int AW = 12
) (
  input  logic          clk_100mhz,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk_100mhz) begin
    if (we)
      mem[addr] <= wdata;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/psram_responder.sv
// Device-side PSRAM bus model: oversamples csn/sclk/data, decodes the
// command/address/dummy/data phases and serves them from on-chip RAM.
module psram_responder
  import psram_pkg::*;
#(
  parameter int         MEM_AW    = 12,
  parameter int         LATENCY   = 4,
  parameter logic [7:0] CMD_WRITE = psram_pkg::CMD_WRITE,
  parameter logic [7:0] CMD_READ  = psram_pkg::CMD_READ
) (
  input  logic              clk_100mhz,
  input  logic              rstn_i,
  psram_responder_if.slave  bus,
  output logic              o_txn_done,
  output logic              o_err,
  output logic [2:0]        o_state
);

  localparam logic [3:0] ADDR_LAST = 4'(ADDR_BYTES - 1);
  localparam logic [3:0] LAT_LAST  = 4'(LATENCY - 1);

  logic       csn_s1, csn_s2, csn_q;
  logic       sclk_s1, sclk_s2, sclk_q;
  logic [7:0] data_s1, data_s2;
  logic [2:0] settle;

  // Sync flops park at the idle bus level; settle marks when csn_s2 first
  // carries a real sample so a csn already low at reset release is caught.
  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      csn_s1  <= 1'b1;
      csn_s2  <= 1'b1;
      csn_q   <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_q  <= 1'b0;
      data_s1 <= '0;
      data_s2 <= '0;
      settle  <= '0;
    end else begin
      csn_s1  <= bus.i_csn;
      csn_s2  <= csn_s1;
      csn_q   <= csn_s2;
      sclk_s1 <= bus.i_sclk;
      sclk_s2 <= sclk_s1;
      sclk_q  <= sclk_s2;
      data_s1 <= bus.i_data;
      data_s2 <= data_s1;
      settle  <= {settle[1:0], 1'b1};
    end
  end

  logic csn_fall, csn_rise, sclk_rise, sclk_fall, boot_check;

  assign csn_fall   = settle[2] & csn_q & ~csn_s2;
  assign csn_rise   = ~csn_q & csn_s2;
  assign sclk_rise  = ~sclk_q & sclk_s2;
  assign sclk_fall  = sclk_q & ~sclk_s2;
  assign boot_check = settle[1] & ~settle[2];

  state_t      state, state_n;
  logic [23:0] addr, addr_n;
  logic [3:0]  cnt, cnt_n;
  logic        is_rd, is_rd_n;
  logic [7:0]  data_q, data_n;
  logic        oe_q, oe_n;
  logic        done_q, done_n;
  logic        err_q, err_n;

  logic              mem_we, mem_re;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= ST_IDLE;
      addr   <= '0;
      cnt    <= '0;
      is_rd  <= 1'b0;
      data_q <= '0;
      oe_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      addr   <= addr_n;
      cnt    <= cnt_n;
      is_rd  <= is_rd_n;
      data_q <= data_n;
      oe_q   <= oe_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  // csn_rise is checked first so a coincident sclk edge is dropped.
  always_comb begin
    state_n   = state;
    addr_n    = addr;
    cnt_n     = cnt;
    is_rd_n   = is_rd;
    data_n    = data_q;
    oe_n      = oe_q;
    done_n    = 1'b0;
    err_n     = err_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = addr[MEM_AW-1:0];
    mem_wdata = data_s2;

    if (state != ST_IDLE && csn_rise) begin
      state_n = ST_IDLE;
      oe_n    = 1'b0;
      done_n  = (state inside {ST_WDATA, ST_RDATA, ST_DUMMY});
    end else begin
      case (state)
        ST_IDLE: begin
          if (boot_check && !csn_s2)
            state_n = ST_IGNORE;
          else if (csn_fall)
            state_n = ST_CMD;
        end
        ST_CMD: begin
          if (sclk_rise) begin
            cnt_n = '0;
            if (data_s2 == CMD_WRITE) begin
              is_rd_n = 1'b0;
              state_n = ST_ADDR;
            end else if (data_s2 == CMD_READ) begin
              is_rd_n = 1'b1;
              state_n = ST_ADDR;
            end else begin
              err_n   = 1'b1;
              state_n = ST_IGNORE;
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            addr_n = {addr[15:0], data_s2};
            cnt_n  = cnt + 4'd1;
            if (cnt == ADDR_LAST) begin
              cnt_n = '0;
              if (!is_rd) begin
                state_n = ST_WDATA;
              end else begin
                mem_re   = 1'b1;
                mem_addr = addr_n[MEM_AW-1:0];
                state_n  = (LATENCY == 0) ? ST_RDATA : ST_DUMMY;
              end
            end
          end
        end
        ST_DUMMY: begin
          if (sclk_rise) begin
            cnt_n = cnt + 4'd1;
            if (cnt == LAT_LAST) begin
              cnt_n   = '0;
              state_n = ST_RDATA;
            end
          end
        end
        ST_RDATA: begin
          if (sclk_fall) begin
            data_n   = mem_rdata;
            oe_n     = 1'b1;
            addr_n   = addr + 24'd1;
            mem_re   = 1'b1;
            mem_addr = addr_n[MEM_AW-1:0];
          end
        end
        ST_WDATA: begin
          if (sclk_rise) begin
            mem_we = 1'b1;
            addr_n = addr + 24'd1;
          end
        end
        ST_IGNORE: begin
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  psram_resp_mem #(.AW(MEM_AW)) u_mem (
    .clk_100mhz (clk_100mhz),
    .we         (mem_we),
    .re         (mem_re),
    .addr       (mem_addr),
    .wdata      (mem_wdata),
    .rdata      (mem_rdata)
  );

  // Raw csn gates the enable so the bus is released without sync delay.
  assign bus.o_data    = data_q;
  assign bus.o_data_oe = oe_q & ~bus.i_csn;
  assign o_txn_done    = done_q;
  assign o_err         = err_q;
  assign o_state       = state;

endmodule
